// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, scoreboard entry type and per-source hazard/forward helpers
// for the D-stage hazard controller.
package hazard_ctrl_pkg;

    localparam logic [2:0] TUSE_NONE = 3'd7;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    // One in-flight writer: destination register (0 = empty) and cycles until result.
    typedef struct packed {
        logic [4:0] a3;
        logic [2:0] tnew;
    } sb_entry_t;

    function automatic logic [2:0] sat_dec(input logic [2:0] x);
        return (x == 3'd0) ? 3'd0 : x - 3'd1;
    endfunction

    // E masks M: an older M writer of the same register is superseded by E.
    function automatic logic src_hazard(input logic [4:0] a,
                                        input logic [2:0] tuse,
                                        input sb_entry_t  e,
                                        input sb_entry_t  m);
        logic haz_e;
        logic haz_m;
        haz_e = (a != 5'd0) && (a == e.a3) && (e.tnew > tuse);
        haz_m = (a != 5'd0) && (a == m.a3) && (a != e.a3) && (m.tnew > tuse);
        return (tuse != TUSE_NONE) && (haz_e || haz_m);
    endfunction

    function automatic logic [1:0] src_fwd(input logic [4:0] a,
                                           input sb_entry_t  e,
                                           input sb_entry_t  m);
        logic [1:0] sel;
        sel = FWD_RF;
        if ((a != 5'd0) && (a == e.a3) && (e.tnew == 3'd0)) begin
            sel = FWD_E;
        end else if ((a != 5'd0) && (a == m.a3) && (m.tnew == 3'd0)) begin
            sel = FWD_M;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// HI/LO busy counter: loads the mult/div latency on an accepted start and
// counts down to zero; busy while non-zero.
module md_busy_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic div,
    output logic busy
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (start) begin
            cnt <= div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign busy = (cnt != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// D-stage stall/forward controller: E/M write scoreboard, register and HI/LO
// hazard detection, and D-stage forward selects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] A1D,
    input  logic [4:0] A2D,
    input  logic [2:0] Tuse1D,
    input  logic [2:0] Tuse2D,
    input  logic [4:0] A3D,
    input  logic [2:0] TnewD,
    input  logic       mdStartD,
    input  logic       mdDivD,
    input  logic       mdUseD,
    output logic       enPC,
    output logic       enD,
    output logic       flushE,
    output logic [1:0] fwdA1D,
    output logic [1:0] fwdA2D,
    output logic       mdBusy
);

    sb_entry_t e_q;
    sb_entry_t m_q;
    logic      haz1;
    logic      haz2;
    logic      md_haz;
    logic      stall;

    // A stalled D instruction must not enter E, so E takes an empty entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
        end else begin
            e_q <= stall ? sb_entry_t'('0) : sb_entry_t'{a3: A3D, tnew: TnewD};
            m_q <= sb_entry_t'{a3: e_q.a3, tnew: sat_dec(e_q.tnew)};
        end
    end

    always_comb begin
        haz1   = src_hazard(A1D, Tuse1D, e_q, m_q);
        haz2   = src_hazard(A2D, Tuse2D, e_q, m_q);
        md_haz = mdUseD && mdBusy;
        stall  = haz1 || haz2 || md_haz;
    end

    assign enPC   = !stall;
    assign enD    = !stall;
    assign flushE = stall;
    assign fwdA1D = src_fwd(A1D, e_q, m_q);
    assign fwdA2D = src_fwd(A2D, e_q, m_q);

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy (
        .clk  (clk),
        .rst  (rst),
        .start(mdStartD && !stall),
        .div  (mdDivD),
        .busy (mdBusy)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl: one vector per D cycle, expected outputs
// queued at drive time and compared at the following negedge.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] A1D, A2D, A3D;
    logic [2:0] Tuse1D, Tuse2D, TnewD;
    logic       mdStartD, mdDivD, mdUseD;
    logic       enPC, enD, flushE, mdBusy;
    logic [1:0] fwdA1D, fwdA2D;

    typedef struct {
        logic       rst;
        logic [4:0] a1;
        logic [2:0] t1;
        logic [4:0] a2;
        logic [2:0] t2;
        logic [4:0] a3;
        logic [2:0] tn;
        logic       mds;
        logic       mdd;
        logic       mdu;
        logic       en;
        logic [1:0] f1;
        logic [1:0] f2;
        logic       busy;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    int          checks;
    int          failures;

    hazard_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .A1D     (A1D),
        .A2D     (A2D),
        .Tuse1D  (Tuse1D),
        .Tuse2D  (Tuse2D),
        .A3D     (A3D),
        .TnewD   (TnewD),
        .mdStartD(mdStartD),
        .mdDivD  (mdDivD),
        .mdUseD  (mdUseD),
        .enPC    (enPC),
        .enD     (enD),
        .flushE  (flushE),
        .fwdA1D  (fwdA1D),
        .fwdA2D  (fwdA2D),
        .mdBusy  (mdBusy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [4:0] a1, input logic [2:0] t1,
                                input logic [4:0] a2, input logic [2:0] t2,
                                input logic [4:0] a3, input logic [2:0] tn,
                                input logic mds, input logic mdd, input logic mdu,
                                input logic en, input logic [1:0] f1, input logic [1:0] f2,
                                input logic busy);
        vec_t v;
        v.rst = r; v.a1 = a1; v.t1 = t1; v.a2 = a2; v.t2 = t2; v.a3 = a3; v.tn = tn;
        v.mds = mds; v.mdd = mdd; v.mdu = mdu;
        v.en = en; v.f1 = f1; v.f2 = f2; v.busy = busy;
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        rst = v.rst; A1D = v.a1; Tuse1D = v.t1; A2D = v.a2; Tuse2D = v.t2;
        A3D = v.a3; TnewD = v.tn; mdStartD = v.mds; mdDivD = v.mdd; mdUseD = v.mdu;
    endtask

    // Expected word {enPC,enD,flushE,fwd1,fwd2,busy}; fwd is masked off while stalled.
    task automatic drive(input vec_t v);
        logic [7:0] e;
        logic [7:0] m;
        @(posedge clk);
        #1;
        set_in(v);
        e = {v.en, v.en, !v.en, v.f1, v.f2, v.busy};
        m = v.en ? 8'hFF : 8'hE1;
        exp_q.push_back({m, e});
    endtask

    task automatic check_out(input int idx);
        logic [15:0] x;
        logic [7:0]  act;
        x   = exp_q.pop_front();
        act = {enPC, enD, flushE, fwdA1D, fwdA2D, mdBusy};
        checks++;
        if ((act & x[15:8]) !== (x[7:0] & x[15:8])) begin
            failures++;
            $display("FAIL vec%0d: got %b expected %b (mask %b)", idx, act, x[7:0], x[15:8]);
        end
    endtask

    initial begin
        vec_t nop;
        int   stalls;
        logic done;
        checks   = 0;
        failures = 0;
        nop = mk(0, 0, 7, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        set_in(nop);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        vecs.push_back(nop);                                            // reset state
        // lw $8 then beq $8: two stall cycles, then no forward
        vecs.push_back(mk(0, 0, 7, 0, 7, 8, 2, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 8, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // addu $9 then beq $9: one stall, then forward from M
        vecs.push_back(mk(0, 0, 7, 0, 7, 9, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 9, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 9, 0, 0, 7, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        // addu $10, lw $10, use with Tuse 1: E entry wins
        vecs.push_back(mk(0, 0, 7, 0, 7, 10, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 7, 10, 2, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // source 2 forwarding from E then from M
        vecs.push_back(mk(0, 0, 7, 0, 7, 11, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7, 11, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 7, 11, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0));
        // Tnew 7 writer: Tuse 7 never stalls, Tuse 5 stalls on the M entry
        vecs.push_back(mk(0, 0, 7, 0, 7, 12, 7, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 12, 7, 12, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 12, 7, 12, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 12, 7, 12, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // register 0
        vecs.push_back(mk(0, 0, 7, 0, 7, 0, 3, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        // same register in E and M, both ready: E has priority
        vecs.push_back(mk(0, 0, 7, 0, 7, 13, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 7, 13, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 13, 0, 13, 3, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(nop);
        // mult; a stalled div must not reload; busy exactly 5 cycles
        vecs.push_back(mk(0, 0, 7, 0, 7, 0, 0, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 7, 0, 0, 1, 1, 1, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 7, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // div issues: busy exactly 10 cycles
        vecs.push_back(mk(0, 0, 7, 0, 7, 0, 0, 1, 1, 1, 1, 0, 0, 0));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 7, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(nop);
        // rst during a register stall, then during an md count
        vecs.push_back(mk(0, 0, 7, 0, 7, 8, 2, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 8, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 7, 0, 0, 1, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 7, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 7, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(nop);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check_out(i);
        end

        // Hand sequence: measure mfhi stall length after mult and after div
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            set_in(mk(0, 0, 7, 0, 7, 0, 0, 1, k[0], 1, 1, 0, 0, 0));
            stalls = 0;
            done   = 1'b0;
            for (int c = 0; c < 30 && !done; c++) begin
                @(posedge clk);
                #1;
                set_in(mk(0, 0, 7, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                @(negedge clk);
                if (enD) done = 1'b1;
                else stalls++;
            end
            checks++;
            if (!done || stalls != ((k == 0) ? 5 : 10)) begin
                failures++;
                $display("FAIL md_stall_len%0d: got %0d cycles (ended=%0b) expected %0d",
                         k, stalls, done, (k == 0) ? 5 : 10);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Stall/forward controller for the D-stage pipeline register of the five-stage MIPS core. Consumes the decoded register addresses and Tuse/Tnew timing fields of the instruction in D. Keeps a two-entry write scoreboard mirroring the E and M stages, plus a HI/LO busy counter for multi-cycle mult/div. Drives the PC enable, the D-register enable, the E-register flush, and D-stage forward selects.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult issues
- DIV_CYCLES, 10, busy cycles after a div issues
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- A1D, A2D  in  5  source register addresses of the instruction in D
- Tuse1D, Tuse2D  in  3  cycles after D before the source is needed; 7 = source unused
- A3D  in  5  destination register of the instruction in D; 0 = no write
- TnewD  in  3  cycles after entering E before the result exists
- mdStartD  in  1  instruction in D is mult/multu/div/divu
- mdDivD  in  1  with mdStartD: 1 = div class, 0 = mult class
- mdUseD  in  1  instruction in D reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- enPC  out  1  PC register enable
- enD  out  1  D-register enable
- flushE  out  1  load a bubble into the E register
- fwdA1D, fwdA2D  out  2  D-stage operand source: 0 = register file, 1 = E result, 2 = M result
- mdBusy  out  1  HI/LO unit busy

## Operation
- Scoreboard: per-stage registers {A3E, TnewE} and {A3M, TnewM}. A3 = 0 means the entry is empty.
- Each edge without rst:
  - E <= stall ? {0,0} : {A3D, TnewD}.
  - M <= {A3E, sat_dec(TnewE)}, where sat_dec(x) = x==0 ? 0 : x-1.
  - W is not tracked; its result reaches D through the register file's write-before-read bypass.
- Register hazard for source i (A = A_iD, T = Tuse_iD):
  - hazE = A!=0 && A==A3E && TnewE > T.
  - hazM = A!=0 && A==A3M && A!=A3E && TnewM > T.
  - E has priority, so an older M entry is masked by a matching E entry.
- HI/LO hazard: mdHaz = mdUseD && mdBusy.
- stall = any register hazard || mdHaz.
- Outputs: enPC = enD = !stall; flushE = stall.
- Forward select for source i, priority E over M:
  - 1 if A!=0 && A==A3E && TnewE==0.
  - else 2 if A!=0 && A==A3M && TnewM==0.
  - else 0.
- Forward select is valid only when stall is 0. It is a don't-care during stall.
- MD counter cnt, 4 bits:
  - Edge with mdStartD && !stall: cnt <= mdDivD ? DIV_CYCLES : MULT_CYCLES.
  - Otherwise, if cnt != 0: cnt <= cnt-1.
  - mdBusy = cnt != 0.
  - A start is blocked by mdHaz while busy (mdStartD implies mdUseD), so a new start never overlaps an active count.

## Timing
- All outputs are combinational from the D inputs and registered state. There is no extra latency.
- Reset values: A3E=A3M=0, TnewE=TnewM=0, cnt=0. After reset: enPC=enD=1, flushE=0, fwd=0, mdBusy=0.
- rst during an active stall or count clears all state at that edge. The stalled D instruction is re-evaluated against an empty scoreboard.
- Simultaneous stall and mdStartD: no load, cnt keeps counting down.
- Tuse 7 never stalls, since Tnew ≤ 7 and the comparison is strict.
- Register 0 never stalls and never forwards.
- Stall duration equals TnewX − Tuse, accounting for the one-cycle decrement per stage advance.

## Structure
- Shared package constants:
  - TUSE_NONE=3'd7.
  - FWD_RF=2'd0, FWD_E=2'd1, FWD_M=2'd2.
  - Default MULT_CYCLES/DIV_CYCLES.
- Sub-module md_busy_counter holds cnt, the load/decrement logic, and mdBusy.
- Scoreboard and hazard/forward comparison live in hazard_ctrl. Per-source comparison logic is replicated for sources 1 and 2.

## Test plan
- lw $8 (A3D=8,TnewD=2), then beq with A1D=8,Tuse1D=0 → stall 2 cycles (TnewE=2, then TnewM=1); third cycle stall=0, fwdA1D=0.
- addu $9 (TnewD=1), then beq with A1D=9,Tuse1D=0 → 1 stall cycle; next cycle fwdA1D=2.
- addu $10 (TnewD=1), then lw with A3D=10,TnewD=2, then A1D=10,Tuse1D=1 → E match wins: stall 1 cycle (TnewE=2 > 1); M entry ignored.
- A3D=0,TnewD=3, then A1D=0,Tuse1D=0 → no stall, fwdA1D=0.
- mult (mdStartD=1,mdDivD=0), then mfhi (mdUseD=1) → mdBusy high exactly 5 cycles; mfhi stalls 5 cycles, then enD=1. Repeat with div: 10 cycles.
- lw $8 then a dependent beq; assert rst in the first stall cycle → next cycle enD=1, flushE=0, cnt=0, all fwd=0.
